gate_truth_table_seq: RTL

Self-checking sequencer for a single 2-input basic gate. On `start` it drives the four input vectors (00, 01, 10, 11) onto the gate under test. It holds each vector for a programmable settle time, samples the gate output, and compares it against a golden truth table for the selected operation. The block sits beside any gate in the basic-gates library and turns the manual truth-table bench into a reusable, synthesizable built-in self-test controller.

---
 rtl/gate_seq_pkg.sv | 27 ++
 rtl/gate_seq_hold_cnt.sv | 32 +++
 rtl/gate_truth_table_seq.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/gate_seq_pkg.sv
// Shared encodings and golden truth table for the gate truth-table sequencer.
package gate_seq_pkg;

   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_XOR  = 2'b10;
   localparam logic [1:0] OP_NAND = 2'b11;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRIVE = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   function automatic logic gate_seq_expected(input logic [1:0] op,
                                              input logic a,
                                              input logic b);
      logic y;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_NAND: y = ~(a & b);
         default: y = ~(a & b);
      endcase
      return y;
   endfunction

endpackage

// File: rtl/gate_seq_hold_cnt.sv
// Loadable down-counter; expire_o is high while the count sits at zero.
module gate_seq_hold_cnt #(
   parameter int unsigned CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             en_i,
   output logic             expire_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (en_i && (cnt_q != '0))
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/gate_truth_table_seq.sv
// Built-in truth-table checker for a 2-input gate.
// Optional first-failure capture: define GATE_SEQ_FIRST_FAIL_EN.
module gate_truth_table_seq
   import gate_seq_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 2,
   parameter int unsigned CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [1:0] op,
   output logic       A,
   output logic       B,
   input  logic       Y,
   output logic       busy,
   output logic       done,
   output logic       pass,
`ifdef GATE_SEQ_FIRST_FAIL_EN
   output logic       first_fail_valid,
   output logic [1:0] first_fail_vec,
`endif
   output logic [3:0] fail_mask
);

   // Counter counts HOLD_CYCLES-1 down to 0, so expiry lands on the H-th edge.
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

   logic [1:0] state_q, state_d;
   logic [1:0] v_q, v_d;
   logic [1:0] op_q, op_d;
   logic [3:0] fail_mask_q, fail_mask_d;
   logic       pass_q, pass_d;
   logic       cnt_load, cnt_en, expire;
   logic       mismatch;
`ifdef GATE_SEQ_FIRST_FAIL_EN
   logic       ff_valid_q, ff_valid_d;
   logic [1:0] ff_vec_q, ff_vec_d;
`endif

   gate_seq_hold_cnt #(.CNT_W(CNT_W)) u_hold_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (cnt_load),
      .load_val_i (HOLD_LOAD),
      .en_i       (cnt_en),
      .expire_o   (expire)
   );

   assign mismatch = (Y != gate_seq_expected(op_q, v_q[1], v_q[0]));
   assign cnt_en   = (state_q == ST_DRIVE);

   always_comb begin
      state_d     = state_q;
      v_d         = v_q;
      op_d        = op_q;
      fail_mask_d = fail_mask_q;
      pass_d      = pass_q;
      cnt_load    = 1'b0;
`ifdef GATE_SEQ_FIRST_FAIL_EN
      ff_valid_d  = ff_valid_q;
      ff_vec_d    = ff_vec_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d     = ST_DRIVE;
               v_d         = '0;
               op_d        = op;
               fail_mask_d = '0;
               pass_d      = 1'b0;
               cnt_load    = 1'b1;
`ifdef GATE_SEQ_FIRST_FAIL_EN
               ff_valid_d  = 1'b0;
               ff_vec_d    = '0;
`endif
            end else if (state_q == ST_DONE) begin
               state_d = ST_IDLE;
            end
         end
         ST_DRIVE: begin
            if (expire) begin
               if (mismatch) begin
                  fail_mask_d[v_q] = 1'b1;
`ifdef GATE_SEQ_FIRST_FAIL_EN
                  if (!ff_valid_q) begin
                     ff_valid_d = 1'b1;
                     ff_vec_d   = v_q;
                  end
`endif
               end
               // Verdict is taken on the entry edge so it is final together with done.
               if (v_q == 2'd3) begin
                  state_d = ST_DONE;
                  pass_d  = (fail_mask_d == '0);
               end else begin
                  v_d      = v_q + 2'd1;
                  cnt_load = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         v_q         <= '0;
         op_q        <= OP_AND;
         fail_mask_q <= '0;
         pass_q      <= 1'b0;
`ifdef GATE_SEQ_FIRST_FAIL_EN
         ff_valid_q  <= 1'b0;
         ff_vec_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         v_q         <= v_d;
         op_q        <= op_d;
         fail_mask_q <= fail_mask_d;
         pass_q      <= pass_d;
`ifdef GATE_SEQ_FIRST_FAIL_EN
         ff_valid_q  <= ff_valid_d;
         ff_vec_q    <= ff_vec_d;
`endif
      end
   end

   assign A         = v_q[1];
   assign B         = v_q[0];
   assign busy      = (state_q == ST_DRIVE);
   assign done      = (state_q == ST_DONE);
   assign pass      = pass_q;
   assign fail_mask = fail_mask_q;
`ifdef GATE_SEQ_FIRST_FAIL_EN
   assign first_fail_valid = ff_valid_q;
   assign first_fail_vec   = ff_vec_q;
`endif

endmodule
